// File: rtl/cpu_clk_pkg.sv
// Shared types and constants for the CPU clock sequencer.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int unsigned MIN_HALF = 1;
  localparam int unsigned DEF_DIV  = 10000000 / 1500000;

  function automatic int unsigned calc_div(input int unsigned sys_freq,
                                           input int unsigned clk_freq);
    return (clk_freq == 0) ? 0 : sys_freq / clk_freq;
  endfunction

endpackage

// File: rtl/cpu_tick_gen.sv
// Half-period tick generator: counts 0..half-1 and pulses tick on the terminal value.
module cpu_tick_gen #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] half,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q >= (half - W'(1)));
    cnt_d = cnt_q + W'(1);
    if (!en || clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cpu_clock_sequencer.sv
// CPU clock sequencer: run / halt / single-step / burst control of a divided CPU clock.
//   state    | meaning
//   ST_IDLE  | cpu_clk parked low, tick counter held, divisor writable
//   ST_RUN   | free-running cpu_clk
//   ST_BURST | counting down remaining rising edges
//   ST_DRAIN | finishing the current high phase before parking
module cpu_clock_sequencer
  import cpu_clk_pkg::*;
#(
  parameter int unsigned SYS_FREQ = 10000000,
  parameter int unsigned DEF_FREQ = 1500000,
  parameter int unsigned DIV_W    = 24,
  parameter int unsigned BURST_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_req,
  input  logic               halt_req,
  input  logic               step_req,
  input  logic               burst_req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               div_wr,
  input  logic [DIV_W-1:0]   div_val,
  output logic               div_err,
  output logic               busy,
  output logic               cpu_clk,
  output logic               cpu_clk_en,
  output logic [15:0]        edge_count
);

  localparam int unsigned RST_DIV = calc_div(SYS_FREQ, DEF_FREQ);

  state_e             state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               cpu_clk_q, cpu_clk_d;
  logic               clk_en_q, clk_en_d;
  logic               div_err_q, div_err_d;
  logic [15:0]        edge_q, edge_d;
  logic [DIV_W-1:0]   half;
  logic               tick, toggle, rise, fall;

  always_comb begin
    half = div_q >> 1;
    if (div_q < DIV_W'(2)) half = DIV_W'(MIN_HALF);
  end

  cpu_tick_gen #(.W(DIV_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state_q != ST_IDLE),
    .clr   (state_d == ST_IDLE),
    .half  (half),
    .tick  (tick)
  );

  // A drain that starts with the clock already low must not begin a new high phase.
  assign toggle = tick && !(state_q == ST_DRAIN && !cpu_clk_q);
  assign rise   = toggle && !cpu_clk_q;
  assign fall   = toggle && cpu_clk_q;

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    div_d     = div_q;
    div_err_d = 1'b0;
    cpu_clk_d = cpu_clk_q ^ toggle;
    clk_en_d  = rise;
    edge_d    = edge_q + 16'(rise);

    case (state_q)
      ST_IDLE: begin
        if (halt_req) begin
          state_d = ST_IDLE;
        end else if (run_req) begin
          state_d = ST_RUN;
        end else if (burst_req && (burst_len != '0)) begin
          state_d = ST_BURST;
          burst_d = burst_len;
        end else if (step_req) begin
          state_d = ST_BURST;
          burst_d = BURST_W'(1);
        end
      end
      ST_RUN: begin
        if (halt_req) state_d = ST_DRAIN;
      end
      ST_BURST: begin
        if (halt_req) begin
          state_d = ST_DRAIN;
        end else if (run_req) begin
          state_d = ST_RUN;
        end else begin
          if (rise) burst_d = burst_q - BURST_W'(1);
          if (fall && (burst_q == '0)) state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!cpu_clk_q || fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (div_wr) begin
      if (state_q == ST_IDLE) div_d     = div_val;
      else                    div_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      burst_q   <= '0;
      div_q     <= DIV_W'(RST_DIV);
      cpu_clk_q <= 1'b0;
      clk_en_q  <= 1'b0;
      div_err_q <= 1'b0;
      edge_q    <= '0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      div_q     <= div_d;
      cpu_clk_q <= cpu_clk_d;
      clk_en_q  <= clk_en_d;
      div_err_q <= div_err_d;
      edge_q    <= edge_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign cpu_clk    = cpu_clk_q;
  assign cpu_clk_en = clk_en_q;
  assign div_err    = div_err_q;
  assign edge_count = edge_q;

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Scoreboard bench: stimulus pushes predicted events, negedge monitors pop and compare.
module tb_cpu_clock_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0, burst_req = 1'b0;
  logic [7:0]  burst_len = '0;
  logic        div_wr = 1'b0;
  logic [23:0] div_val = '0;
  logic        div_err, busy, cpu_clk, cpu_clk_en;
  logic [15:0] edge_count;

  cpu_clock_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .burst_req  (burst_req),
    .burst_len  (burst_len),
    .div_wr     (div_wr),
    .div_val    (div_val),
    .div_err    (div_err),
    .busy       (busy),
    .cpu_clk    (cpu_clk),
    .cpu_clk_en (cpu_clk_en),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [15:0] cnt;
  } rise_t;

  rise_t       rise_q[$];
  int          idle_q[$];
  int          err_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cur_h = 3;
  int          model_div = 10000000 / 1500000;
  logic [15:0] model_edges = '0;
  bit          mon_on = 0;
  bit          skip_hi = 0;
  int          hi_len = 0;
  logic        prev_clk = 1'b0, prev_busy = 1'b0;
  rise_t       mon_r;
  int          mon_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitors: rising-edge pulses, divisor errors, return to idle, high-phase width.
  always @(negedge clk) begin
    if (mon_on) begin
      if (cpu_clk_en) begin
        checks++;
        if (rise_q.size() == 0) begin
          errors++;
          $display("FAIL rise_unexpected cycle=%0d edge_count=%0d", cyc, edge_count);
        end else begin
          mon_r = rise_q.pop_front();
          if (mon_r.t != cyc || mon_r.cnt !== edge_count || cpu_clk !== 1'b1) begin
            errors++;
            $display("FAIL rise got cycle=%0d edge_count=%0d clk=%b exp cycle=%0d edge_count=%0d clk=1",
                     cyc, edge_count, cpu_clk, mon_r.t, mon_r.cnt);
          end
        end
      end
      if (div_err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL div_err_unexpected cycle=%0d", cyc);
        end else begin
          mon_t = err_q.pop_front();
          if (mon_t != cyc) begin
            errors++;
            $display("FAIL div_err got cycle=%0d exp cycle=%0d", cyc, mon_t);
          end
        end
      end
      if (prev_busy && !busy) begin
        checks++;
        if (idle_q.size() == 0) begin
          errors++;
          $display("FAIL idle_unexpected cycle=%0d", cyc);
        end else begin
          mon_t = idle_q.pop_front();
          if (mon_t != cyc) begin
            errors++;
            $display("FAIL idle_time got cycle=%0d exp cycle=%0d", cyc, mon_t);
          end
        end
      end
      if (cpu_clk === 1'b1) begin
        hi_len++;
      end else begin
        if (prev_clk === 1'b1 && !skip_hi) chk("high_phase_len", hi_len, cur_h);
        hi_len = 0;
      end
      if (busy === 1'b0) chk("idle_clk_low", cpu_clk, 0);
      prev_clk  = cpu_clk;
      prev_busy = busy;
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_div();
    int opts[8];
    opts = '{1, 2, 3, 6, 7, 20, 25, 11};
    return opts[$urandom_range(0, 7)];
  endfunction

  // op: 0 run, 1 step, 2 burst, 3 run+step together, 4 burst of length 0; -1 random.
  task automatic session(input int force_op, input int force_div);
    int op, n, a, h, hh, cc, ee, idle, k, rises, ww, gg, dv, ig_kind;
    bit run_mode, halt_en, conv_en, bad_en, ign_en;
    op = (force_op >= 0) ? force_op : $urandom_range(0, 4);
    dv = 0;
    if (force_div > 0) dv = force_div;
    else if (force_op < 0 && $urandom_range(0, 1) == 1) dv = pick_div();
    if (dv > 0) begin
      div_wr = 1'b1;
      div_val = 24'(dv);
      step_clk();
      div_wr = 1'b0;
      model_div = dv;
      step_clk();
    end
    h = (model_div < 2) ? 1 : model_div / 2;
    cur_h = h;
    n = 0;
    case (op)
      0: run_req = 1'b1;
      1: begin step_req = 1'b1; n = 1; end
      2: begin burst_req = 1'b1; n = $urandom_range(1, 8); burst_len = 8'(n); end
      3: begin run_req = 1'b1; step_req = 1'b1; end
      default: begin burst_req = 1'b1; burst_len = 8'd0; end
    endcase
    run_mode = (op == 0 || op == 3);
    a = cyc + 1;
    step_clk();
    run_req = 1'b0; step_req = 1'b0; burst_req = 1'b0;
    if (op == 4) begin
      repeat (4) step_clk();
      chk("burst0_busy", busy, 0);
      chk("burst0_edges", edge_count, model_edges);
      return;
    end
    ee = a + 2 * n * h;
    conv_en = !run_mode && force_op < 0 && ($urandom_range(0, 2) == 0);
    cc = conv_en ? $urandom_range(a + 1, ee) : 0;
    if (conv_en) run_mode = 1;
    halt_en = run_mode || (force_op < 0 && $urandom_range(0, 1) == 1);
    if (run_mode) hh = (conv_en ? cc : a) + $urandom_range(1, 6 * h + 2);
    else if (halt_en) hh = $urandom_range(a + 1, ee);
    else hh = 0;
    if (halt_en) begin
      k = (hh - a) / h;
      rises = (k + 1) / 2;
      idle = (k % 2 == 1) ? a + (k + 1) * h : hh + 1;
    end else begin
      rises = n;
      idle = ee;
    end
    for (int j = 0; j < rises; j++)
      rise_q.push_back('{a + h + 2 * j * h, 16'(int'(model_edges) + j + 1)});
    idle_q.push_back(idle);
    bad_en = ($urandom_range(0, 2) == 0);
    ww = $urandom_range(a + 1, idle);
    if (bad_en) err_q.push_back(ww);
    ign_en = (op == 0 || op == 3) && (hh > a + 1) && ($urandom_range(0, 1) == 1);
    gg = (hh > a + 1) ? $urandom_range(a + 1, hh - 1) : 0;
    ig_kind = $urandom_range(0, 2);
    while (cyc < idle + 2) begin
      halt_req  = halt_en && (cyc + 1 == hh);
      run_req   = (conv_en && (cyc + 1 == cc)) || (ign_en && ig_kind == 0 && (cyc + 1 == gg));
      step_req  = ign_en && ig_kind == 1 && (cyc + 1 == gg);
      burst_req = ign_en && ig_kind == 2 && (cyc + 1 == gg);
      burst_len = 8'd3;
      div_wr    = bad_en && (cyc + 1 == ww);
      div_val   = 24'($urandom_range(1, 30));
      step_clk();
    end
    halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0; burst_req = 1'b0; div_wr = 1'b0;
    chk("end_busy", busy, 0);
    chk("end_clk", cpu_clk, 0);
    chk("end_edge_count", edge_count, 16'(int'(model_edges) + rises));
    model_edges = 16'(int'(model_edges) + rises);
  endtask

  // Reset lands one cycle after the second rise while running; a run request in the same cycle is dropped.
  task automatic reset_session();
    int a, h, r;
    h = (model_div < 2) ? 1 : model_div / 2;
    cur_h = h;
    run_req = 1'b1;
    a = cyc + 1;
    step_clk();
    run_req = 1'b0;
    r = a + 3 * h + 1;
    rise_q.push_back('{a + h, 16'(int'(model_edges) + 1)});
    rise_q.push_back('{a + 3 * h, 16'(int'(model_edges) + 2)});
    idle_q.push_back(r);
    while (cyc + 1 < r) step_clk();
    chk("pre_reset_clk", cpu_clk, 1);
    reset = 1'b1;
    run_req = 1'b1;
    skip_hi = 1;
    step_clk();
    chk("rst_clk", cpu_clk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_edge_count", edge_count, 0);
    chk("rst_clk_en", cpu_clk_en, 0);
    reset = 1'b0;
    run_req = 1'b0;
    step_clk();
    skip_hi = 0;
    chk("post_rst_busy", busy, 0);
    model_edges = '0;
    model_div = 10000000 / 1500000;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_clk", cpu_clk, 0);
    chk("reset_clk_en", cpu_clk_en, 0);
    chk("reset_div_err", div_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_edge_count", edge_count, 0);
    reset = 1'b0;
    mon_on = 1;
    step_clk();
    session(0, 0);
    session(1, 0);
    session(2, 0);
    session(0, 20);
    session(0, 1);
    session(4, 0);
    session(3, 0);
    session(1, 6);
    for (int s = 0; s < 30; s++) session(-1, 0);
    reset_session();
    session(1, 0);
    repeat (5) step_clk();
    chk("rise_queue_drained", rise_q.size(), 0);
    chk("idle_queue_drained", idle_q.size(), 0);
    chk("err_queue_drained", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog cycle=%0d exp=finish", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
